// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus initiator and the agents on the same bus.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } bus_state_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// Core request/response handshake plus the Memory address and direction lines.
interface mem_bus_master_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] address_bus;
  logic              write_mode;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata, address_bus, write_mode
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, address_bus, write_mode
  );

endinterface

// File: rtl/mem_bus_master.sv
// Single-outstanding bus initiator: turns core load/store requests into Memory
// cycles on a shared tristate data bus and returns one completion pulse each.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_master_if.master     bus,
  inout  wire   [DATA_W-1:0]   data_bus
);

  bus_state_t        state;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lat_cnt         <= 3'd0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.address_bus <= '0;
      bus.write_mode  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            if (bus.req_addr[0]) begin
              // Misaligned: complete with an error, bus lines untouched.
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.address_bus <= bus.req_addr;
              if (bus.req_write) begin
                state          <= WRITE;
                bus.write_mode <= 1'b1;
              end else begin
                state   <= READ;
                lat_cnt <= 3'(READ_LAT);
              end
            end
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.write_mode <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
        end
        READ: begin
          // Counter runs READ_LAT..0, so READ spans READ_LAT+1 cycles.
          if (lat_cnt == 3'd0) begin
            state          <= RESP;
            bus.resp_rdata <= data_bus;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Store data is only ever consumed from WRITE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      wdata_q <= bus.req_wdata;
    end
  end

  assign data_bus = (state == WRITE) ? wdata_q : {DATA_W{1'bz}};

endmodule
